// File: rtl/ta_ldd_cmd_seq.sv
// LDD command initiator: turns one pulse-train request into open/close strobes for the LDD receiver.
// Latency: com_open is 1 cycle after accept; the pulse period is 1+on+off cycles; done comes 1 cycle after the last ON, CLOSE or aborted GAP.
// Backpressure: req_ready is high only in IDLE, so a request waits until the current train has fully finished.
module ta_ldd_cmd_seq #(
   parameter int TOP0_0 = 3,
   parameter int LDD0_0 = 32,
   parameter int REP_W  = 16
) (
   input  logic              clk200,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [TOP0_0-1:0] req_wdis,
   input  logic [LDD0_0-1:0] req_on,
   input  logic [LDD0_0-1:0] req_off,
   input  logic [REP_W-1:0]  req_rep,
   input  logic              abort,
   output logic [TOP0_0-1:0] com_wdis,
   output logic [LDD0_0-1:0] com_plus,
   output logic              com_open,
   output logic              com_close,
   output logic              busy,
   output logic              done,
   output logic [REP_W-1:0]  pulse_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_OPEN  = 3'd1,
      S_ON    = 3'd2,
      S_GAP   = 3'd3,
      S_CLOSE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [LDD0_0-1:0] on_cnt;
   logic [LDD0_0-1:0] off_cnt;
   logic [LDD0_0-1:0] off_len;
   logic [REP_W-1:0]  rep_len;
   logic              accept;
   logic              on_last;
   logic              rep_hit;

   // com_plus holds the latched on-width for the whole train, so it also
   // serves as the reload value for the ON counter.
   assign req_ready = (state == S_IDLE);
   assign accept    = req_valid && req_ready;
   assign on_last   = (on_cnt == LDD0_0'(1));
   assign rep_hit   = (rep_len != '0) && ((pulse_cnt + REP_W'(1)) == rep_len);

   // Next-state selection; abort always takes priority over counter expiry.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = S_OPEN;
         end
         S_OPEN: begin
            state_nxt = abort ? S_CLOSE : S_ON;
         end
         S_ON: begin
            if (abort) begin
               state_nxt = S_CLOSE;
            end else if (com_plus != '0 && on_last) begin
               if (rep_hit)              state_nxt = S_DONE;
               else if (off_len == '0)   state_nxt = S_OPEN;
               else                      state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            // The receiver is already off in the gap, so an abort needs no close.
            if (abort)                          state_nxt = S_DONE;
            else if (off_cnt == LDD0_0'(1))     state_nxt = S_OPEN;
         end
         S_CLOSE: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, counters and registered Moore outputs decoded from the next state.
   always_ff @(posedge clk200) begin
      if (rst) begin
         state     <= S_IDLE;
         on_cnt    <= '0;
         off_cnt   <= '0;
         off_len   <= '0;
         rep_len   <= '0;
         com_wdis  <= '0;
         com_plus  <= '0;
         com_open  <= 1'b0;
         com_close <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pulse_cnt <= '0;
      end else begin
         state     <= state_nxt;
         com_open  <= (state_nxt == S_OPEN);
         com_close <= (state_nxt == S_CLOSE);
         done      <= (state_nxt == S_DONE);
         busy      <= (state_nxt != S_IDLE);

         if (accept) begin
            com_wdis  <= req_wdis;
            com_plus  <= req_on;
            off_len   <= req_off;
            rep_len   <= req_rep;
            pulse_cnt <= '0;
         end else if (state_nxt == S_IDLE) begin
            com_wdis <= '0;
            com_plus <= '0;
         end

         case (state)
            S_OPEN: begin
               on_cnt <= com_plus;
            end
            S_ON: begin
               if (!abort && com_plus != '0) begin
                  on_cnt <= on_cnt - LDD0_0'(1);
                  if (on_last) pulse_cnt <= pulse_cnt + REP_W'(1);
               end
            end
            S_GAP: begin
               off_cnt <= off_cnt - LDD0_0'(1);
            end
            default: ;
         endcase

         if (state_nxt == S_GAP && state != S_GAP) off_cnt <= off_len;
      end
   end

endmodule

// File: tb/tb_ta_ldd_cmd_seq.sv
module tb_ta_ldd_cmd_seq;
   localparam int TW = 3;
   localparam int LW = 32;
   localparam int RW = 16;

   logic          clk200 = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [TW-1:0] req_wdis;
   logic [LW-1:0] req_on;
   logic [LW-1:0] req_off;
   logic [RW-1:0] req_rep;
   logic          abort;
   logic [TW-1:0] com_wdis;
   logic [LW-1:0] com_plus;
   logic          com_open;
   logic          com_close;
   logic          busy;
   logic          done;
   logic [RW-1:0] pulse_cnt;

   ta_ldd_cmd_seq #(.TOP0_0(TW), .LDD0_0(LW), .REP_W(RW)) dut (
      .clk200(clk200), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_wdis(req_wdis), .req_on(req_on), .req_off(req_off), .req_rep(req_rep),
      .abort(abort), .com_wdis(com_wdis), .com_plus(com_plus), .com_open(com_open),
      .com_close(com_close), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
   );

   always #5 clk200 = ~clk200;

   int cyc = 0;
   always @(posedge clk200) cyc <= cyc + 1;

   // kind: 0 = com_open, 1 = com_close, 2 = done
   typedef struct {
      int kind;
      int at;
      int pcnt;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int kind, input int at, input int pcnt);
      ev_t e;
      e.kind = kind;
      e.at   = at;
      e.pcnt = pcnt;
      exp_q.push_back(e);
   endtask

   task automatic mon(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event actual kind=%0d at cyc %0d required none", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_cycle", cyc, e.at);
         if (kind == 2) chk("done_pulse_cnt", pulse_cnt, e.pcnt);
      end
   endtask

   // Monitor: every strobe the DUT presents is matched against the scoreboard.
   always @(negedge clk200) begin
      if (!rst) begin
         if (com_open)  mon(0);
         if (com_close) mon(1);
         if (done)      mon(2);
      end
   end

   task automatic wait_cyc(input int t);
      @(negedge clk200);
      while (cyc < t) @(negedge clk200);
   endtask

   // Issue a request; base is chosen so that spec cycle N maps to cyc == base+N.
   task automatic start(input int w, input int on, input int off, input int rep, output int base);
      @(negedge clk200);
      req_valid = 1'b1;
      req_wdis  = TW'(w);
      req_on    = LW'(on);
      req_off   = LW'(off);
      req_rep   = RW'(rep);
      chk("req_ready_idle", req_ready, 1);
      @(posedge clk200);
      #1;
      req_valid = 1'b0;
      base = cyc - 1;
   endtask

   task automatic pulse_abort(input int t);
      wait_cyc(t);
      abort = 1'b1;
      @(posedge clk200);
      #1;
      abort = 1'b0;
   endtask

   task automatic chk_idle(input int pcnt);
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_wdis", com_wdis, 0);
      chk("idle_plus", com_plus, 0);
      chk("idle_pulse_cnt", pulse_cnt, pcnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      rst = 1'b1; req_valid = 1'b0; abort = 1'b0;
      req_wdis = '0; req_on = '0; req_off = '0; req_rep = '0;
      repeat (3) @(posedge clk200);
      @(negedge clk200);
      chk("rst_open", com_open, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_pulse_cnt", pulse_cnt, 0);
      rst = 1'b0;
      // abort in IDLE must be ignored
      abort = 1'b1;
      repeat (2) @(negedge clk200);
      abort = 1'b0;
      chk("abort_idle_busy", busy, 0);

      // 1: wdis=5 on=4 off=2 rep=3
      start(5, 4, 2, 3, b);
      push(0, b + 1, 0); push(0, b + 8, 0); push(0, b + 15, 0); push(2, b + 20, 3);
      wait_cyc(b + 2);
      chk("t1_wdis", com_wdis, 5);
      chk("t1_plus", com_plus, 4);
      chk("t1_busy", busy, 1);
      chk("t1_ready", req_ready, 0);
      wait_cyc(b + 21);
      chk_idle(3);

      // 2: on=3 off=0 rep=2, back-to-back pulses, no close
      start(1, 3, 0, 2, b);
      push(0, b + 1, 0); push(0, b + 5, 0); push(2, b + 9, 2);
      wait_cyc(b + 10);
      chk_idle(2);

      // 3: on=0 (hold) rep=7, abort in cycle 10
      start(2, 0, 3, 7, b);
      push(0, b + 1, 0); push(1, b + 11, 0); push(2, b + 12, 0);
      pulse_abort(b + 10);
      wait_cyc(b + 13);
      chk_idle(0);

      // 4: on=2 off=5 continuous, abort in first GAP
      start(3, 2, 5, 0, b);
      push(0, b + 1, 0); push(2, b + 6, 1);
      pulse_abort(b + 5);
      wait_cyc(b + 7);
      chk_idle(1);

      // 5: on=2 off=1 continuous, abort on last ON cycle of second pulse
      start(4, 2, 1, 0, b);
      push(0, b + 1, 0); push(0, b + 5, 0); push(1, b + 8, 0); push(2, b + 9, 1);
      pulse_abort(b + 7);
      wait_cyc(b + 10);
      chk_idle(1);

      // 6: request while busy is held off, then rst mid-ON
      start(7, 10, 0, 0, b);
      push(0, b + 1, 0);
      wait_cyc(b + 2);
      req_valid = 1'b1; req_wdis = 3'd6; req_on = 32'd1;
      chk("t6_ready_busy", req_ready, 0);
      wait_cyc(b + 4);
      chk("t6_wdis_held", com_wdis, 7);
      chk("t6_plus_held", com_plus, 10);
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk200);
      #1;
      rst = 1'b0;
      chk("t6_rst_open", com_open, 0);
      chk("t6_rst_close", com_close, 0);
      chk("t6_rst_done", done, 0);
      chk_idle(0);

      repeat (5) @(negedge clk200);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
